// File: rtl/matrix_stream_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// matrix_stream_ctrl_pkg
// Shared definitions for the matrix stream controller:
//   - default matrix dimension, operand/result widths and watchdog limit
//   - FSM state encoding
//   - idx_width(): width of an element index covering 0 .. n*n-1
// ---------------------------------------------------------------------------
package matrix_stream_ctrl_pkg;

  localparam int MSC_N           = 4;
  localparam int MSC_DATA_W      = 8;
  localparam int MSC_RES_W       = 16;
  localparam int MSC_TIMEOUT_CYC = 64;

  typedef enum logic [2:0] {
    LOAD_A,
    LOAD_B,
    KICK,
    WAIT,
    STREAM
  } state_t;

  function automatic int idx_width(input int n);
    return (n * n > 1) ? $clog2(n * n) : 1;
  endfunction

endpackage

// File: rtl/mat_idx_counter.sv
// ---------------------------------------------------------------------------
// mat_idx_counter
// Element index for an N x N matrix walked in row-major order.
// Ports:
//   clk, rst  clock / asynchronous active-high reset
//   clr       force idx to 0 (wins over inc)
//   inc       advance idx by one; saturates at N*N-1 so idx never exceeds it
//   idx       current element index
//   tc        terminal count, high while idx == N*N-1
// ---------------------------------------------------------------------------
module mat_idx_counter
  import matrix_stream_ctrl_pkg::*;
#(
  parameter int N = MSC_N,
  localparam int IDX_W = idx_width(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [IDX_W-1:0] idx,
  output logic             tc
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N * N - 1);

  assign tc = (idx == LAST);

  // NOTE: sequential state is written with <= only, so every flop samples
  // the values from before the edge regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
    end else if (clr) begin
      idx <= '0;
    end else if (inc && !tc) begin
      idx <= idx + 1'b1;
    end
  end

endmodule

// File: rtl/matrix_stream_ctrl.sv
// ---------------------------------------------------------------------------
// matrix_stream_ctrl
// Loads two N x N operand matrices from a single element stream (A then B,
// row-major), kicks an external matrix unit, waits for its completion edge,
// captures the result and streams it back out row-major.
// Ports:
//   clk, rst              clock / asynchronous active-high reset
//   in_valid/in_ready     operand stream handshake, in_data element
//   mat_a, mat_b          registered operands to the matrix unit
//   mat_start             one-cycle start pulse
//   mat_done, mat_c       unit completion level and result
//   out_valid/out_ready   result stream handshake, out_data element,
//                         out_last flags element N*N-1
//   busy                  high unless idle in LOAD_A with idx 0
//   err_timeout           sticky watchdog flag
// Build option:
//   MATRIX_DONE_TIMEOUT_EN  enables the WAIT watchdog (TIMEOUT_CYC cycles);
//                           without it WAIT waits forever and err_timeout=0.
// ---------------------------------------------------------------------------
module matrix_stream_ctrl
  import matrix_stream_ctrl_pkg::*;
#(
  parameter int N           = MSC_N,
  parameter int DATA_W      = MSC_DATA_W,
  parameter int RES_W       = MSC_RES_W,
  parameter int TIMEOUT_CYC = MSC_TIMEOUT_CYC
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [DATA_W-1:0]                   in_data,
  output logic [N-1:0][N-1:0][DATA_W-1:0]     mat_a,
  output logic [N-1:0][N-1:0][DATA_W-1:0]     mat_b,
  output logic                                mat_start,
  input  logic                                mat_done,
  input  logic [N-1:0][N-1:0][RES_W-1:0]      mat_c,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [RES_W-1:0]                    out_data,
  output logic                                out_last,
  output logic                                busy,
  output logic                                err_timeout
);

  localparam int IDX_W = idx_width(N);

  state_t                        state;
  logic [IDX_W-1:0]              idx;
  logic                          tc;
  // Flat row-major views: element i*N+j of these is element [i][j] of the
  // 2-D ports, so the stream index addresses them directly.
  logic [N*N-1:0][DATA_W-1:0]    a_q;
  logic [N*N-1:0][DATA_W-1:0]    b_q;
  logic [N*N-1:0][RES_W-1:0]     res_buf;
  logic                          done_q;
  logic                          load_beat;
  logic                          out_hs;
  logic                          done_edge;

  assign in_ready  = (state == LOAD_A) || (state == LOAD_B);
  assign load_beat = in_valid && in_ready;
  // out_valid is only ever high in STREAM, so out_ready is ignored elsewhere.
  assign out_hs    = out_valid && out_ready;
  assign done_edge = mat_done && !done_q;

  assign mat_a     = a_q;
  assign mat_b     = b_q;
  assign out_data  = out_valid ? res_buf[idx] : '0;
  assign out_last  = out_valid && tc;
  assign busy      = !((state == LOAD_A) && (idx == '0));

  // Each phase (load A, load B, stream) ends on its last beat, which also
  // returns the index to 0 for the next phase.
  mat_idx_counter #(.N(N)) u_idx (
    .clk (clk),
    .rst (rst),
    .clr ((load_beat || out_hs) && tc),
    .inc (load_beat || out_hs),
    .idx (idx),
    .tc  (tc)
  );

`ifdef MATRIX_DONE_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);
  logic [WAIT_W-1:0] wait_cnt;
`else
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= LOAD_A;
      // NOTE: the operand and result buffers are flops, not RAM, and a reset
      // must leave no stale data visible, so they are cleared here too.
      a_q       <= '0;
      b_q       <= '0;
      res_buf   <= '0;
      mat_start <= 1'b0;
      out_valid <= 1'b0;
      done_q    <= 1'b0;
`ifdef MATRIX_DONE_TIMEOUT_EN
      wait_cnt    <= '0;
      err_timeout <= 1'b0;
`endif
    end else begin
      done_q    <= mat_done;
      mat_start <= 1'b0;
      case (state)
        LOAD_A: begin
          if (load_beat) begin
            a_q[idx] <= in_data;
            if (tc) state <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (load_beat) begin
            b_q[idx] <= in_data;
            if (tc) begin
              state     <= KICK;
              mat_start <= 1'b1;
            end
          end
        end
        KICK: begin
          state <= WAIT;
`ifdef MATRIX_DONE_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        WAIT: begin
          if (done_edge) begin
            res_buf   <= mat_c;
            out_valid <= 1'b1;
            state     <= STREAM;
          end
`ifdef MATRIX_DONE_TIMEOUT_EN
          else if (wait_cnt == WAIT_LAST) begin
            err_timeout <= 1'b1;
            state       <= LOAD_A;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        STREAM: begin
          if (out_hs && tc) begin
            out_valid <= 1'b0;
            state     <= LOAD_A;
          end
        end
        default: state <= LOAD_A;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_stream_ctrl.sv
// ---------------------------------------------------------------------------
// tb_matrix_stream_ctrl
// Directed bench for matrix_stream_ctrl with a behavioural matrix unit that
// answers mat_start with c = a - b after a fixed latency (or never, when
// model_hang is set).
// ---------------------------------------------------------------------------
module tb_matrix_stream_ctrl;

  localparam int N         = 4;
  localparam int DATA_W    = 8;
  localparam int RES_W     = 16;
  localparam int MODEL_LAT = 20;

  logic                            clk;
  logic                            rst;
  logic                            in_valid;
  logic                            in_ready;
  logic [DATA_W-1:0]               in_data;
  logic [N-1:0][N-1:0][DATA_W-1:0] mat_a;
  logic [N-1:0][N-1:0][DATA_W-1:0] mat_b;
  logic                            mat_start;
  logic                            mat_done;
  logic [N-1:0][N-1:0][RES_W-1:0]  mat_c;
  logic                            out_valid;
  logic                            out_ready;
  logic [RES_W-1:0]                out_data;
  logic                            out_last;
  logic                            busy;
  logic                            err_timeout;

  matrix_stream_ctrl #(
    .N(N), .DATA_W(DATA_W), .RES_W(RES_W), .TIMEOUT_CYC(64)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mat_a(mat_a), .mat_b(mat_b), .mat_start(mat_start),
    .mat_done(mat_done), .mat_c(mat_c),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural matrix unit.
  bit model_hang = 1'b0;
  int model_cnt  = 0;
  int start_pulses = 0;
  always @(posedge clk) begin
    mat_done <= 1'b0;
    if (rst) begin
      model_cnt <= 0;
    end else if (mat_start) begin
      start_pulses <= start_pulses + 1;
      model_cnt    <= MODEL_LAT;
    end else if (model_cnt != 0) begin
      model_cnt <= model_cnt - 1;
      if (model_cnt == 1 && !model_hang) begin
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++)
            mat_c[i][j] <= RES_W'(mat_a[i][j]) - RES_W'(mat_b[i][j]);
        mat_done <= 1'b1;
      end
    end
  end

  // Monitors of accepted input beats and cycles with out_valid high.
  int acc_cnt = 0;
  int ov_cnt  = 0;
  always @(posedge clk) begin
    if (in_valid && in_ready) acc_cnt++;
    if (out_valid) ov_cnt++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  int               va [16];
  int               vb [16];
  logic [RES_W-1:0] got_data [16];
  logic             got_last [16];
  int               stall_err;
  int               inrdy_err;

  // Stream A then B; 'gap' idle cycles follow each beat.
  task automatic load_all(input int gap);
    int t;
    for (int k = 0; k < 32; k++) begin
      in_data  = DATA_W'(k < 16 ? va[k] : vb[k-16]);
      in_valid = 1'b1;
      t = 0;
      while (!in_ready && t < 100) begin
        @(posedge clk); #1; t++;
      end
      if (t >= 100) check("load_ready_timeout", 32'(k), 32'hFFFF_FFFF);
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  // Accept up to max_beats results; toggle drives out_ready = cycle parity.
  task automatic collect(input int max_beats, input bit toggle, output int nbeats);
    int               cyc;
    bit               prev_stall;
    logic [RES_W-1:0] prev_d;
    logic             prev_l;
    cyc = 0; nbeats = 0; prev_stall = 0; prev_d = '0; prev_l = 0;
    stall_err = 0; inrdy_err = 0;
    while (nbeats < max_beats && cyc < 500) begin
      out_ready = toggle ? cyc[0] : 1'b1;
      if (in_ready) inrdy_err++;
      if (out_valid) begin
        if (prev_stall && (out_data !== prev_d || out_last !== prev_l)) stall_err++;
        if (out_ready) begin
          got_data[nbeats] = out_data;
          got_last[nbeats] = out_last;
          nbeats++;
          prev_stall = 0;
        end else begin
          prev_stall = 1;
          prev_d = out_data;
          prev_l = out_last;
        end
      end
      @(posedge clk); #1; cyc++;
    end
    out_ready = 1'b0;
  endtask

  int n;
  int s0;
  int a0;
  int o0;
  int bad;
  int lasts;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    mat_done = 1'b0; mat_c = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_mat_start", 32'(mat_start), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_out_last", 32'(out_last), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_err_timeout", 32'(err_timeout), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_mat_a", 32'(mat_a != '0), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Run 1: A = 9, B = 4 -> sixteen 5s, last only on beat 16.
    for (int k = 0; k < 16; k++) begin va[k] = 9; vb[k] = 4; end
    s0 = start_pulses;
    load_all(0);
    check("t1_start_level", 32'(mat_start), 1);
    check("t1_busy_kick", 32'(busy), 1);
    collect(16, 1'b0, n);
    check("t1_beats", 32'(n), 16);
    bad = 0; lasts = 0;
    for (int k = 0; k < 16; k++) begin
      if (got_data[k] !== 16'd5) bad++;
      if (got_last[k]) lasts++;
    end
    check("t1_data_bad", 32'(bad), 0);
    check("t1_last_count", 32'(lasts), 1);
    check("t1_last_on_16", 32'(got_last[15]), 1);
    check("t1_start_pulses", 32'(start_pulses - s0), 1);
    check("t1_in_ready_low", 32'(inrdy_err), 0);
    check("t1_idle_busy", 32'(busy), 0);
    check("t1_idle_in_ready", 32'(in_ready), 1);
    check("t1_idle_out_valid", 32'(out_valid), 0);

    // Run 2: A[i][j] = 4i+j, B = 0, out_ready toggles -> 0..15 with stalls.
    for (int k = 0; k < 16; k++) begin va[k] = k; vb[k] = 0; end
    load_all(0);
    collect(16, 1'b1, n);
    check("t2_beats", 32'(n), 16);
    for (int k = 0; k < 16; k++) check($sformatf("t2_data_%0d", k), 32'(got_data[k]), 32'(k));
    check("t2_stall_stable", 32'(stall_err), 0);
    check("t2_last_on_16", 32'(got_last[15]), 1);
    check("t2_last_early", 32'(got_last[14]), 0);

    // Run 3: gapped input (1 on, 2 off), A = k, B = 1 -> k-1 (0 wraps to FFFF);
    // in_valid stays high after the load and must be ignored.
    for (int k = 0; k < 16; k++) begin va[k] = k; vb[k] = 1; end
    a0 = acc_cnt;
    load_all(2);
    in_valid = 1'b1; in_data = 8'hEE;
    collect(16, 1'b0, n);
    in_valid = 1'b0;
    check("t3_accepted", 32'(acc_cnt - a0), 32);
    check("t3_beats", 32'(n), 16);
    check("t3_data_0", 32'(got_data[0]), 32'h0000_FFFF);
    check("t3_data_9", 32'(got_data[9]), 8);
    check("t3_data_15", 32'(got_data[15]), 14);
    check("t3_in_ready_low", 32'(inrdy_err), 0);
    check("t3_mat_a_00", 32'(mat_a[0][0]), 0);
    check("t3_mat_a_33", 32'(mat_a[3][3]), 15);
    check("t3_mat_b_12", 32'(mat_b[1][2]), 1);

    // Run 4: reset after seven result beats, then a fresh run.
    for (int k = 0; k < 16; k++) begin va[k] = 3; vb[k] = 1; end
    load_all(0);
    collect(7, 1'b0, n);
    check("t4_pre_beats", 32'(n), 7);
    check("t4_pre_data", 32'(got_data[6]), 2);
    check("t4_pre_valid", 32'(out_valid), 1);
    rst = 1'b1;
    #1;
    check("t4_rst_out_valid", 32'(out_valid), 0);
    check("t4_rst_busy", 32'(busy), 0);
    check("t4_rst_in_ready", 32'(in_ready), 1);
    check("t4_rst_out_data", 32'(out_data), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    o0 = ov_cnt;
    repeat (30) begin @(posedge clk); #1; end
    check("t4_no_stale_beats", 32'(ov_cnt - o0), 0);
    for (int k = 0; k < 16; k++) begin va[k] = 9; vb[k] = 4; end
    load_all(0);
    collect(16, 1'b0, n);
    check("t4_new_beats", 32'(n), 16);
    bad = 0;
    for (int k = 0; k < 16; k++) if (got_data[k] !== 16'd5) bad++;
    check("t4_new_data_bad", 32'(bad), 0);

    // Run 5: the unit never completes.
    model_hang = 1'b1;
    load_all(0);
    check("t5_start_level", 32'(mat_start), 1);
    o0 = ov_cnt;
    @(posedge clk); #1;  // first WAIT cycle begins
`ifdef MATRIX_DONE_TIMEOUT_EN
    repeat (63) begin @(posedge clk); #1; end
    check("t5_err_before", 32'(err_timeout), 0);
    check("t5_busy_before", 32'(busy), 1);
    @(posedge clk); #1;
    check("t5_err_after", 32'(err_timeout), 1);
    check("t5_load_a_busy", 32'(busy), 0);
    check("t5_load_a_ready", 32'(in_ready), 1);
    repeat (10) begin @(posedge clk); #1; end
    check("t5_err_sticky", 32'(err_timeout), 1);
`else
    repeat (100) begin @(posedge clk); #1; end
    check("t5_err_tied", 32'(err_timeout), 0);
    check("t5_wait_busy", 32'(busy), 1);
    check("t5_wait_ready", 32'(in_ready), 0);
`endif
    check("t5_no_out_valid", 32'(ov_cnt - o0), 0);
    rst = 1'b1;
    #1;
    check("t5_rst_err", 32'(err_timeout), 0);
    rst = 1'b0;
    model_hang = 1'b0;
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
